// File: rtl/alu_seq_unit_if.sv
// Operand/result handshake bundle for alu_seq_unit.
// master drives operands and consumes results; slave is the unit.
interface alu_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] x;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, a, b, alu, out_ready,
        input  in_ready, out_valid, x,
        input  flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
        input  in_valid, a, b, alu, out_ready,
        output in_ready, out_valid, x,
        output flag_z, flag_n, flag_c, flag_v
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked WIDTH-bit ALU: add/sub/logic/slt in one cycle,
// shift-add multiply in WIDTH iterations, registered result and flags.
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic          clk,
    input logic          rst_n,
    alu_seq_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic                 z_q, z_d;
    logic                 n_q, n_d;
    logic                 c_q, c_d;
    logic                 v_q, v_d;

    logic [WIDTH:0]       add_s;
    logic [WIDTH:0]       sub_s;
    logic                 sa, sb;
    logic                 add_v, sub_v, lt;
    logic [WIDTH-1:0]     res_x;
    logic                 res_c, res_v;
    logic [2*WIDTH-1:0]   acc_step;
    logic                 last;

    assign add_s = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_s = {1'b0, bus.a} + {1'b0, ~bus.b}
                 + {{WIDTH{1'b0}}, 1'b1};
    assign sa    = bus.a[WIDTH-1];
    assign sb    = bus.b[WIDTH-1];
    assign add_v = (sa == sb) && (add_s[WIDTH-1] != sa);
    assign sub_v = (sa != sb) && (sub_s[WIDTH-1] != sa);
    // Sign of a-b corrected by overflow gives the true signed compare.
    assign lt    = sub_s[WIDTH-1] ^ sub_v;

    always_comb begin
        res_x = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (bus.alu)
            OP_ADD: begin
                res_x = add_s[WIDTH-1:0];
                res_c = add_s[WIDTH];
                res_v = add_v;
            end
            OP_SUB: begin
                res_x = sub_s[WIDTH-1:0];
                res_c = sub_s[WIDTH];
                res_v = sub_v;
            end
            OP_AND: res_x = bus.a & bus.b;
            OP_OR:  res_x = bus.a | bus.b;
            OP_XOR: res_x = bus.a ^ bus.b;
            OP_SLT: res_x = {{(WIDTH-1){1'b0}}, lt};
            default: res_x = '0;
        endcase
    end

    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign last     = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.alu == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        x_d     = res_x;
                        z_d     = (res_x == '0);
                        n_d     = res_x[WIDTH-1];
                        c_d     = res_c;
                        v_d     = res_v;
                        state_d = DONE;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    x_d     = acc_step[WIDTH-1:0];
                    z_d     = (acc_step[WIDTH-1:0] == '0);
                    n_d     = acc_step[WIDTH-1];
                    c_d     = 1'b0;
                    v_d     = |acc_step[2*WIDTH-1:WIDTH];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.x         = x_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
endmodule
